// File: rtl/addsub_flags_pipe.sv
// Two-stage split-carry adder/subtractor with registered z/v/n flags for the ALU compare path.
// Stage 1 adds the low half and registers the mid carry; stage 2 completes the high half and the flags.
module addsub_flags_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             aluop_three,
    input  logic             aluop_one,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             z,
    output logic             v,
    output logic             n,
    output logic             aluop_three_out,
    output logic             aluop_one_out
);

    localparam int unsigned L   = WIDTH / 2;
    localparam int unsigned LP1 = L + 1;

    logic [WIDTH-1:0] bx;
    logic [L:0]       lo_full;
    logic             s2_free;
    logic             s1_adv;
    logic             in_fire;

    logic             s1_valid;
    logic [L-1:0]     s1_lo;
    logic             s1_cmid;
    logic [L-1:0]     s1_ahi;
    logic [L-1:0]     s1_bhi;
    logic             s1_op3;
    logic             s1_op1;

    logic [L-1:0]     hi_sum;
    logic [WIDTH-1:0] sum_next;
    logic             v_next;

    // Subtraction is A + ~B + 1, with the +1 entering as the low-half carry-in.
    always_comb begin
        bx      = sub ? ~b : b;
        lo_full = LP1'(a[L-1:0]) + LP1'(bx[L-1:0]) + LP1'(sub);
    end

    // Handshake: stage 1 may refill in the same cycle it hands off to stage 2.
    always_comb begin
        s2_free  = !out_valid || out_ready;
        s1_adv   = s1_valid && s2_free;
        in_ready = !s1_valid || s2_free;
        in_fire  = in_valid && in_ready;
    end

    always_comb begin
        hi_sum   = s1_ahi + s1_bhi + L'(s1_cmid);
        sum_next = {hi_sum, s1_lo};
        v_next   = (s1_ahi[L-1] == s1_bhi[L-1]) && (hi_sum[L-1] != s1_ahi[L-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_cmid  <= 1'b0;
            s1_ahi   <= '0;
            s1_bhi   <= '0;
            s1_op3   <= 1'b0;
            s1_op1   <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_lo    <= lo_full[L-1:0];
                s1_cmid  <= lo_full[L];
                s1_ahi   <= a[WIDTH-1:L];
                s1_bhi   <= bx[WIDTH-1:L];
                s1_op3   <= aluop_three;
                s1_op1   <= aluop_one;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Output data only reloads on advance, so it holds under backpressure and while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            sum             <= '0;
            z               <= 1'b0;
            v               <= 1'b0;
            n               <= 1'b0;
            aluop_three_out <= 1'b0;
            aluop_one_out   <= 1'b0;
        end else begin
            if (s1_adv) begin
                out_valid       <= 1'b1;
                sum             <= sum_next;
                z               <= (sum_next == '0);
                v               <= v_next;
                n               <= sum_next[WIDTH-1];
                aluop_three_out <= s1_op3;
                aluop_one_out   <= s1_op1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_addsub_flags_pipe.sv
// Bench for addsub_flags_pipe: directed vector table, handshake corner sequences and a
// randomized run, all checked through an in-order scoreboard of expected results.
module tb_addsub_flags_pipe;

    typedef struct packed {
        logic [31:0] sum;
        logic        z;
        logic        v;
        logic        n;
        logic        op3;
        logic        op1;
    } res_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        o3;
        logic        o1;
        logic [31:0] es;
        logic        ez;
        logic        ev;
        logic        en;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        aluop_three;
    logic        aluop_one;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        z;
    logic        v;
    logic        n;
    logic        aluop_three_out;
    logic        aluop_one_out;

    int   checks;
    int   errors;
    res_t exp_cur;
    res_t sb[$];
    res_t mon_exp;
    res_t mon_act;

    addsub_flags_pipe #(.WIDTH(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .a               (a),
        .b               (b),
        .sub             (sub),
        .aluop_three     (aluop_three),
        .aluop_one       (aluop_one),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .sum             (sum),
        .z               (z),
        .v               (v),
        .n               (n),
        .aluop_three_out (aluop_three_out),
        .aluop_one_out   (aluop_one_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic ms, input logic mo3, input logic mo1);
        logic [31:0] r;
        logic        ov;
        r = ms ? (ma - mb) : (ma + mb);
        if (ms) ov = (ma[31] != mb[31]) && (r[31] != ma[31]);
        else    ov = (ma[31] == mb[31]) && (r[31] != ma[31]);
        return '{sum: r, z: (r == 32'h0), v: ov, n: r[31], op3: mo3, op1: mo1};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                          input logic o3, input logic o1, input res_t e);
        a           = ta;
        b           = tbv;
        sub         = ts;
        aluop_three = o3;
        aluop_one   = o1;
        exp_cur     = e;
        in_valid    = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the op.
    task automatic send(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                        input logic o3, input logic o1, input res_t e);
        int waited;
        set_in(ta, tbv, ts, o3, o1, e);
        waited = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stuck at 0 for a=%h b=%h", ta, tbv);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: pop before push, since an output leaving this cycle is always older.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                mon_act = '{sum: sum, z: z, v: v, n: n, op3: aluop_three_out, op1: aluop_one_out};
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got %h with no result outstanding", mon_act);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_act !== mon_exp) begin
                        errors++;
                        $display("FAIL result: got %h expected %h", mon_act, mon_exp);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(exp_cur);
        end
    end

    initial begin
        vec_t vecs[10];
        res_t e;
        int   waited;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        aluop_three = 1'b0;
        aluop_one = 1'b0;
        out_ready = 1'b1;
        exp_cur = '0;

        vecs[0] = '{32'd5,         32'd3,         1'b1, 1'b0, 1'b1, 32'd2,         1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'd1,         1'b0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{32'h8000_0000, 32'd1,         1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_FFFF, 32'd1,         1'b0, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0};
        vecs[6] = '{32'h0,         32'd1,         1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 32'h0,         1'b1, 1'b1, 1'b0};
        vecs[8] = '{32'd3,         32'd5,         1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{32'h0000_FFFF, 32'hFFFF_0000, 1'b1, 1'b1, 1'b0, 32'h0001_FFFF, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", {out_valid, sum, z, v, n, aluop_three_out, aluop_one_out, in_ready},
              {1'b0, 32'h0, 5'b0, 1'b1});

        // Latency: accepted at edge k, visible after edge k+1.
        @(posedge clk);
        #1 set_in(32'd5, 32'd3, 1'b1, 1'b0, 1'b1, model(32'd5, 32'd3, 1'b1, 1'b0, 1'b1));
        @(negedge clk);
        check("lat_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("lat_edge_k", out_valid, 1'b0);
        @(negedge clk);
        check("lat_edge_k1", {out_valid, sum, z, v, n}, {1'b1, 32'd2, 3'b000});

        // Directed table streamed back to back.
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            e = '{sum: vecs[i].es, z: vecs[i].ez, v: vecs[i].ev, n: vecs[i].en,
                  op3: vecs[i].o3, op1: vecs[i].o1};
            send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].o3, vecs[i].o1, e);
        end
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: two ops fill the pipe, the third is held off.
        out_ready = 1'b0;
        send(32'd1, 32'd1, 1'b0, 1'b1, 1'b0, '{32'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        send(32'd2, 32'd2, 1'b0, 1'b0, 1'b1, '{32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        set_in(32'd3, 32'd3, 1'b0, 1'b1, 1'b1, '{32'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        @(negedge clk);
        check("bp_full", {in_ready, out_valid, sum}, {1'b0, 1'b1, 32'd2});
        @(negedge clk);
        check("bp_hold", {in_ready, out_valid, sum, aluop_three_out, aluop_one_out},
              {1'b0, 1'b1, 32'd2, 2'b10});
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_out0", {in_ready, out_valid, sum}, {1'b1, 1'b1, 32'd2});
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_out1", {out_valid, sum, aluop_three_out, aluop_one_out}, {1'b1, 32'd4, 2'b01});
        @(negedge clk);
        check("bp_out2", {out_valid, sum, aluop_three_out, aluop_one_out}, {1'b1, 32'd6, 2'b11});
        @(negedge clk);
        check("bp_drained", out_valid, 1'b0);

        // Reset with two ops in flight.
        @(posedge clk);
        #1;
        send(32'd10, 32'd20, 1'b0, 1'b1, 1'b1, model(32'd10, 32'd20, 1'b0, 1'b1, 1'b1));
        send(32'd7, 32'd9, 1'b1, 1'b1, 1'b0, model(32'd7, 32'd9, 1'b1, 1'b1, 1'b0));
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_flush", {out_valid, sum, z, v, n, aluop_three_out, aluop_one_out, in_ready},
              {1'b0, 32'h0, 5'b0, 1'b1});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_stale", out_valid, 1'b0);
        end

        // Random stress with random valid/ready.
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rs;
            logic        r3;
            logic        r1;
            @(posedge clk);
            #1;
            ra = pick_operand();
            rb = pick_operand();
            rs = 1'($urandom_range(0, 1));
            r3 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            set_in(ra, rb, rs, r3, r1, model(ra, rb, rs, r3, r1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'd0);
        check("final_idle", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
